// File: rtl/bbtron_pkg.sv
// Shared widths, address/word types and the REG_BYPASS_EN build switch for the
// register file and its neighbours (ALU, writeback).
package bbtron_pkg;

    localparam int unsigned DATA_W   = 32;
    localparam int unsigned NUM_REGS = 32;
    localparam int unsigned ADDR_W   = 5;

    typedef logic [DATA_W-1:0] word_t;
    typedef logic [ADDR_W-1:0] reg_addr_t;

    localparam reg_addr_t ZERO_REG = 5'd0;

    // Same-edge write-to-read forwarding; when off, the pipeline inserts a bubble.
`ifdef REG_BYPASS_EN
    localparam bit BYPASS_EN = 1'b1;
`else
    localparam bit BYPASS_EN = 1'b0;
`endif

endpackage

// File: rtl/register_bank_if.sv
// Read/write bus of the register file: master is the pipeline, slave is register_bank.
interface register_bank_if #(
    parameter int unsigned DATA_W = bbtron_pkg::DATA_W,
    parameter int unsigned ADDR_W = bbtron_pkg::ADDR_W
);

    logic              rd_en;
    logic [ADDR_W-1:0] rs_addr;
    logic [ADDR_W-1:0] rt_addr;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [DATA_W-1:0] data1;
    logic [DATA_W-1:0] data2;
    logic              rd_valid;

    modport master (
        output rd_en, rs_addr, rt_addr, wr_en, wr_addr, wr_data,
        input  data1, data2, rd_valid
    );

    modport slave (
        input  rd_en, rs_addr, rt_addr, wr_en, wr_addr, wr_data,
        output data1, data2, rd_valid
    );

endinterface

// File: rtl/register_bank_reg_read_port.sv
// One registered read port: address decode, r0/out-of-range zeroing,
// optional same-edge bypass (REG_BYPASS_EN) and the operand output register.
module reg_read_port
    import bbtron_pkg::*;
#(
    parameter int unsigned DATA_W   = bbtron_pkg::DATA_W,
    parameter int unsigned NUM_REGS = bbtron_pkg::NUM_REGS,
    parameter int unsigned ADDR_W   = bbtron_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rd_en_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] regs_i [NUM_REGS],
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    output logic [DATA_W-1:0] data_o
);

    logic [DATA_W-1:0] data_d;
    logic [DATA_W-1:0] data_q;
    logic              in_range;
    logic              fwd_hit;

    always_comb begin
        in_range = (32'(addr_i) < NUM_REGS) && (addr_i != ZERO_REG);
        fwd_hit  = BYPASS_EN && wr_en_i && (wr_addr_i != ZERO_REG) && (wr_addr_i == addr_i);
        data_d   = data_q;
        if (rd_en_i) begin
            if (!in_range) begin
                data_d = '0;
            end else if (fwd_hit) begin
                data_d = wr_data_i;
            end else begin
                data_d = regs_i[addr_i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign data_o = data_q;

endmodule

// File: rtl/register_bank.sv
// Two-read/one-write register file feeding the ALU; r0 reads as zero.
// Same-edge forwarding is selected at build time by REG_BYPASS_EN.
module register_bank
    import bbtron_pkg::*;
#(
    parameter int unsigned DATA_W   = bbtron_pkg::DATA_W,
    parameter int unsigned NUM_REGS = bbtron_pkg::NUM_REGS,
    parameter int unsigned ADDR_W   = bbtron_pkg::ADDR_W
) (
    input  logic           clk,
    input  logic           rst_n,
    register_bank_if.slave bus
);

    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic              rd_valid_q;
    logic              wr_hit;

    // r0 is never written, so it stays at its reset value of zero.
    assign wr_hit = bus.wr_en && (bus.wr_addr != ZERO_REG) && (32'(bus.wr_addr) < NUM_REGS);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_hit) begin
            regs_q[bus.wr_addr] <= bus.wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= bus.rd_en;
        end
    end

    reg_read_port #(
        .DATA_W   (DATA_W),
        .NUM_REGS (NUM_REGS),
        .ADDR_W   (ADDR_W)
    ) u_port_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .rd_en_i   (bus.rd_en),
        .addr_i    (bus.rs_addr),
        .regs_i    (regs_q),
        .wr_en_i   (bus.wr_en),
        .wr_addr_i (bus.wr_addr),
        .wr_data_i (bus.wr_data),
        .data_o    (bus.data1)
    );

    reg_read_port #(
        .DATA_W   (DATA_W),
        .NUM_REGS (NUM_REGS),
        .ADDR_W   (ADDR_W)
    ) u_port_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .rd_en_i   (bus.rd_en),
        .addr_i    (bus.rt_addr),
        .regs_i    (regs_q),
        .wr_en_i   (bus.wr_en),
        .wr_addr_i (bus.wr_addr),
        .wr_data_i (bus.wr_data),
        .data_o    (bus.data2)
    );

    assign bus.rd_valid = rd_valid_q;

endmodule

// File: tb/tb_register_bank.sv
// Directed bench for register_bank with a scoreboard of expected operand pairs;
// honours REG_BYPASS_EN the same way the design build does.
module tb_register_bank;
    import bbtron_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    register_bank_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    register_bank #(
        .DATA_W   (DATA_W),
        .NUM_REGS (NUM_REGS),
        .ADDR_W   (ADDR_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    word_t model [NUM_REGS];
    word_t exp_q [$];
    word_t last1;
    word_t last2;
    int    checks = 0;
    int    passed = 0;
    int    fails  = 0;

    task automatic check(input string tag, input word_t obs, input word_t exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic word_t ref_val(input reg_addr_t a, input bit we, input reg_addr_t wa,
                                      input word_t wd);
        if (a == ZERO_REG || 32'(a) >= NUM_REGS) return '0;
`ifdef REG_BYPASS_EN
        if (we && wa != ZERO_REG && wa == a) return wd;
`endif
        return model[a];
    endfunction

    task automatic clear_model();
        for (int i = 0; i < NUM_REGS; i++) model[i] = '0;
        exp_q.delete();
        last1 = '0;
        last2 = '0;
    endtask

    // One clock: drive, push expectations, take the edge, then compare #1 later.
    task automatic step(input bit rd, input reg_addr_t rs, input reg_addr_t rt,
                        input bit we, input reg_addr_t wa, input word_t wd, input string tag);
        word_t e1;
        word_t e2;
        bus.rd_en   = rd;
        bus.rs_addr = rs;
        bus.rt_addr = rt;
        bus.wr_en   = we;
        bus.wr_addr = wa;
        bus.wr_data = wd;
        if (rd) begin
            exp_q.push_back(ref_val(rs, we, wa, wd));
            exp_q.push_back(ref_val(rt, we, wa, wd));
        end
        @(posedge clk);
        if (we && wa != ZERO_REG && 32'(wa) < NUM_REGS) model[wa] = wd;
        #1;
        bus.rd_en = 1'b0;
        bus.wr_en = 1'b0;
        if (rd) begin
            check({tag, "_valid"}, word_t'(bus.rd_valid), word_t'(1));
            e1 = exp_q.pop_front();
            e2 = exp_q.pop_front();
            check({tag, "_data1"}, bus.data1, e1);
            check({tag, "_data2"}, bus.data2, e2);
            last1 = e1;
            last2 = e2;
        end else begin
            check({tag, "_valid"}, word_t'(bus.rd_valid), word_t'(0));
            check({tag, "_hold1"}, bus.data1, last1);
            check({tag, "_hold2"}, bus.data2, last2);
        end
    endtask

    initial begin
        bus.rd_en   = 1'b0;
        bus.rs_addr = '0;
        bus.rt_addr = '0;
        bus.wr_en   = 1'b0;
        bus.wr_addr = '0;
        bus.wr_data = '0;
        clear_model();

        #1;
        check("por_data1", bus.data1, '0);
        check("por_data2", bus.data2, '0);
        check("por_valid", word_t'(bus.rd_valid), '0);
        @(negedge clk);
        rst_n = 1'b1;

        // 1: load r1..r31, read some back, then reset mid-cycle.
        for (int i = 1; i < 32; i++)
            step(1'b0, '0, '0, 1'b1, reg_addr_t'(i), 32'h1000_0000 + 32'(i) * 32'h0101_0101, "load");
        step(1'b1, reg_addr_t'(5), reg_addr_t'(31), 1'b0, '0, '0, "preload_rd");
        #2;
        rst_n = 1'b0;
        #1;
        clear_model();
        check("rst_data1", bus.data1, '0);
        check("rst_data2", bus.data2, '0);
        check("rst_valid", word_t'(bus.rd_valid), '0);
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b0, '0, '0, 1'b0, '0, '0, "post_rst");
        for (int i = 0; i < 16; i++)
            step(1'b1, reg_addr_t'(i), reg_addr_t'(i + 16), 1'b0, '0, '0, "rst_clear");

        // 2: write r5, read it, then idle cycle holds data.
        step(1'b0, '0, '0, 1'b1, reg_addr_t'(5), 32'hDEADBEEF, "w5");
        step(1'b1, reg_addr_t'(5), reg_addr_t'(0), 1'b0, '0, '0, "r5");
        step(1'b0, '0, '0, 1'b0, '0, '0, "r5_idle");

        // 3: r0 write dropped.
        step(1'b0, '0, '0, 1'b1, reg_addr_t'(0), 32'h00001234, "w0");
        step(1'b1, reg_addr_t'(0), reg_addr_t'(0), 1'b0, '0, '0, "r0");

        // 4: same-edge read/write of r7, then plain read.
        step(1'b0, '0, '0, 1'b1, reg_addr_t'(7), 32'h11111111, "w7");
        step(1'b1, reg_addr_t'(7), reg_addr_t'(0), 1'b1, reg_addr_t'(7), 32'hA5A5A5A5, "rw7");
        step(1'b1, reg_addr_t'(7), reg_addr_t'(7), 1'b0, '0, '0, "r7_after");
        check("r7_new", bus.data1, 32'hA5A5A5A5);

        // 5: all-ones in top register on both ports.
        step(1'b0, '0, '0, 1'b1, reg_addr_t'(31), 32'hFFFFFFFF, "w31");
        step(1'b1, reg_addr_t'(31), reg_addr_t'(31), 1'b0, '0, '0, "r31");

        // 6: back-to-back reads of 1..4 while r4 is rewritten every cycle.
        for (int i = 1; i <= 4; i++)
            step(1'b1, reg_addr_t'(i), reg_addr_t'(4), 1'b1, reg_addr_t'(4),
                 32'hC0DE_0000 + 32'(i), "b2b");
        step(1'b0, '0, '0, 1'b0, '0, '0, "b2b_end");
        step(1'b1, reg_addr_t'(4), reg_addr_t'(3), 1'b0, '0, '0, "r4_final");

        check("sb_empty", word_t'(exp_q.size()), '0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
